int_log_dispatch: RTL

//  Operand issue stage directly upstream of the 64-bit logic unit. Buffers
//  (operation, opa, opb) requests in a small FIFO and drives one request at a

---
 rtl/int_log_dispatch.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/int_log_dispatch.sv
// Operand issue stage for the 64-bit logic unit: request FIFO, fixed-latency issue FSM, result hold register.
// Optional build macro INT_LOG_OPCODE_CHECK_EN traps opcode 3'b111 at pop instead of issuing it.
module int_log_dispatch #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_opa,
  input  logic [WIDTH-1:0] in_opb,
  output logic [2:0]       lu_op,
  output logic [WIDTH-1:0] lu_opa,
  output logic [WIDTH-1:0] lu_opb,
  input  logic [WIDTH-1:0] lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_op,
  output logic             res_err,
  output logic             busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (LU_LAT > 1) ? $clog2(LU_LAT) : 1;
  localparam logic [2:0]  OP_UNDEF = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       fifo_op [DEPTH];
  logic [WIDTH-1:0] fifo_a  [DEPTH];
  logic [WIDTH-1:0] fifo_b  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [TW-1:0]    cnt, cnt_nxt;
  logic [2:0]       head_op;
  logic             push, pop, empty;
  logic             load, capture, trap, clr_valid, head_illegal;

  assign in_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  assign head_op  = fifo_op[rd_ptr];
  assign busy     = (state != S_IDLE) || !empty;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= in_op;
      fifo_a[wr_ptr]  <= in_opa;
      fifo_b[wr_ptr]  <= in_opb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Issue from IDLE and from HOLD share the same load/trap decision on the FIFO head.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    trap      = 1'b0;
    clr_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_illegal) begin
            trap      = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            load      = 1'b1;
            cnt_nxt   = TW'(LU_LAT - 1);
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          cnt_nxt = cnt - TW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          clr_valid = 1'b1;
          if (!empty) begin
            pop = 1'b1;
            if (head_illegal) begin
              trap      = 1'b1;
              state_nxt = S_HOLD;
            end else begin
              load      = 1'b1;
              cnt_nxt   = TW'(LU_LAT - 1);
              state_nxt = S_WAIT;
            end
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lu_op     <= '0;
      lu_opa    <= '0;
      lu_opb    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (load) begin
        lu_op  <= head_op;
        lu_opa <= fifo_a[rd_ptr];
        lu_opb <= fifo_b[rd_ptr];
      end
      // A new result takes priority over the handshake that retires the old one.
      if (capture) begin
        res_data  <= lu_out;
        res_op    <= lu_op;
        res_valid <= 1'b1;
      end else if (trap) begin
        res_data  <= '0;
        res_op    <= OP_UNDEF;
        res_valid <= 1'b1;
      end else if (clr_valid) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef INT_LOG_OPCODE_CHECK_EN
  assign head_illegal = (head_op == OP_UNDEF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    res_err <= 1'b0;
    else if (trap)                 res_err <= 1'b1;
    else if (capture || clr_valid) res_err <= 1'b0;
  end
`else
  assign head_illegal = 1'b0;
  assign res_err      = 1'b0;
`endif

endmodule
